fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM between the pc block, instruction memory and decode.
// Defining FETCH_PERF_EN adds the fetch_count / stall_count performance counters.
module fetch_unit #(
  parameter int ADDR_W  = 20,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_inc,
  input  logic               redirect,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  input  logic               instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

  logic [1:0]         state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] instr_q;
  logic               kill_q;
  logic               inc_pending_q;

  // A redirect seen while the request is outstanding poisons the eventual ack;
  // a redirect arriving with the ack itself is folded in directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      instr_q       <= '0;
      kill_q        <= 1'b0;
      inc_pending_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          addr_q  <= pc;
          kill_q  <= 1'b0;
          state_q <= ST_REQ;
        end
        ST_REQ: begin
          if (mem_ack) begin
            if (kill_q || redirect) begin
              state_q <= ST_IDLE;
            end else begin
              instr_q       <= mem_rdata;
              inc_pending_q <= 1'b1;
              state_q       <= ST_VALID;
            end
          end else if (redirect) begin
            kill_q <= 1'b1;
          end
        end
        ST_VALID: begin
          inc_pending_q <= 1'b0;
          if (redirect || instr_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req     = (state_q == ST_REQ);
  assign mem_addr    = (state_q == ST_REQ) ? addr_q : '0;
  assign instr_valid = (state_q == ST_VALID);
  assign instr       = instr_q;
  assign pc_inc      = inc_pending_q & ~redirect;

`ifdef FETCH_PERF_EN
  logic accept;
  logic stall;

  // Redirect wins over ready, so a dropped instruction is not counted as fetched.
  assign accept = (state_q == ST_VALID) & instr_ready & ~redirect;
  assign stall  = ((state_q == ST_REQ) & ~mem_ack) | ((state_q == ST_VALID) & ~instr_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (accept) fetch_count <= fetch_count + 32'd1;
      if (stall)  stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit with a bench-side pc block and memory model.
// Perf counter checks are compiled in when FETCH_PERF_EN is defined.
module tb_fetch_unit;
  localparam int ADDR_W  = 20;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic [ADDR_W-1:0]  pc;
  logic               pc_inc;
  logic               redirect;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               instr_ready;
`ifdef FETCH_PERF_EN
  logic [31:0]        fetch_count;
  logic [31:0]        stall_count;
`endif

  fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_inc      (pc_inc),
    .redirect    (redirect),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int tests_run  = 0;
  int fail_count = 0;
  logic [INSTR_W-1:0] exp_q[$];
  int cyc          = 0;
  int accepted     = 0;
  int last_acc_cyc = 0;
  int inc_count    = 0;
  logic               obs_req, obs_valid, obs_inc;
  logic [ADDR_W-1:0]  obs_addr;
  logic [INSTR_W-1:0] obs_instr;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, answer memory from mem_addr, observe, then advance the pc model.
  task automatic apply_stimulus(input logic ack, input logic rdy, input logic redir,
                                input logic [ADDR_W-1:0] target);
    mem_ack     = ack;
    instr_ready = rdy;
    redirect    = redir;
    #1;
    mem_rdata = 32'hA000_0000 | {12'h000, mem_addr};
    #1;
    obs_req   = mem_req;
    obs_addr  = mem_addr;
    obs_valid = instr_valid;
    obs_instr = instr;
    obs_inc   = pc_inc;
    if (obs_valid && rdy && !redir) begin
      accepted++;
      last_acc_cyc = cyc;
      if (exp_q.size() == 0) check_output("sb_unexpected_accept", 64'(exp_q.size()), 64'd1);
      else                   check_output("sb_instr", 64'(obs_instr), 64'(exp_q.pop_front()));
    end
    if (obs_inc) inc_count++;
    @(posedge clk);
    #1;
    cyc++;
    if (redir)        pc = target;
    else if (obs_inc) pc = pc + 1'b1;
  endtask

  initial begin
    int prev_acc;
    int prev_cyc;
    int inc_base;
    int acc_base;

    rst         = 1'b0;
    pc          = '0;
    mem_ack     = 1'b1;
    mem_rdata   = '0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    #1;
    check_output("rst_instr_valid", 64'(instr_valid), 64'd0);
    check_output("rst_mem_req", 64'(mem_req), 64'd0);
    check_output("rst_pc_inc", 64'(pc_inc), 64'd0);
    check_output("rst_instr", 64'(instr), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_hold_instr_valid", 64'(instr_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("idle_mem_req", 64'(mem_req), 64'd0);
    @(posedge clk);
    #1;
    check_output("first_mem_req", 64'(mem_req), 64'd1);
    check_output("first_mem_addr", 64'(mem_addr), 64'h0);

    // Streaming: 64 fetches at one per 3 cycles.
    for (int i = 0; i < 64; i++) exp_q.push_back(32'hA000_0000 | i);
    for (int n = 0; n < 64 * 3 + 6 && accepted < 64; n++) begin
      prev_acc = accepted;
      prev_cyc = last_acc_cyc;
      apply_stimulus(1'b1, 1'b1, 1'b0, '0);
      if (accepted != prev_acc && accepted > 1)
        check_output("stream_spacing", 64'(last_acc_cyc - prev_cyc), 64'd3);
    end
    check_output("stream_count", 64'(accepted), 64'd64);
    check_output("stream_pc_inc", 64'(inc_count), 64'd64);
    check_output("stream_pc", 64'(pc), 64'd64);
`ifdef FETCH_PERF_EN
    check_output("perf_fetch_stream", 64'(fetch_count), 64'd64);
    check_output("perf_stall_stream", 64'(stall_count), 64'd0);
`endif

    // Memory wait: ack five cycles late at 0x3BEEF.
    pc       = 20'h3BEEF;
    inc_base = inc_count;
    exp_q.push_back(32'hA003_BEEF);
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    check_output("idle_addr_zero", 64'(obs_addr), 64'h0);
    for (int k = 0; k < 6; k++) begin
      apply_stimulus((k == 5), 1'b1, 1'b0, '0);
      check_output("wait_mem_req", 64'(obs_req), 64'd1);
      check_output("wait_mem_addr", 64'(obs_addr), 64'h3BEEF);
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    check_output("wait_valid", 64'(obs_valid), 64'd1);
    check_output("wait_pc_inc_once", 64'(inc_count - inc_base), 64'd1);
`ifdef FETCH_PERF_EN
    check_output("perf_stall_wait", 64'(stall_count), 64'd5);
    check_output("perf_fetch_wait", 64'(fetch_count), 64'd65);
`endif

    // Redirect during an outstanding request: the stale ack must vanish.
    inc_base = inc_count;
    acc_base = accepted;
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 20'h01000);
    check_output("kill_req_held", 64'(obs_req), 64'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    check_output("kill_no_valid", 64'(obs_valid), 64'd0);
    check_output("kill_no_pc_inc", 64'(inc_count - inc_base), 64'd0);
    check_output("kill_no_accept", 64'(accepted - acc_base), 64'd0);
    exp_q.push_back(32'hA000_1000);
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    check_output("redirect_mem_addr", 64'(obs_addr), 64'h01000);

    // Back-pressure then redirect in VALID drops the instruction.
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, '0);
      check_output("bp_valid", 64'(obs_valid), 64'd1);
      check_output("bp_instr", 64'(obs_instr), 64'hA000_1000);
    end
    acc_base = accepted;
    apply_stimulus(1'b0, 1'b1, 1'b1, 20'h02000);
    check_output("drop_pc_inc", 64'(obs_inc), 64'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    check_output("drop_valid", 64'(obs_valid), 64'd0);
    check_output("drop_no_accept", 64'(accepted - acc_base), 64'd0);
    check_output("drop_sb_pending", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
`ifdef FETCH_PERF_EN
    check_output("perf_fetch_drop", 64'(fetch_count), 64'd65);
    check_output("perf_stall_drop", 64'(stall_count), 64'd11);
`endif

    // Reset in the middle of a request.
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    check_output("midreq_req", 64'(obs_req), 64'd1);
    check_output("midreq_addr", 64'(obs_addr), 64'h02000);
    mem_ack = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_output("async_mem_req", 64'(mem_req), 64'd0);
    check_output("async_mem_addr", 64'(mem_addr), 64'h0);
    check_output("async_instr", 64'(instr), 64'd0);
    check_output("async_valid", 64'(instr_valid), 64'd0);
    mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("late_ack_ignored", 64'(mem_req), 64'd0);
`ifdef FETCH_PERF_EN
    check_output("perf_fetch_rst", 64'(fetch_count), 64'd0);
    check_output("perf_stall_rst", 64'(stall_count), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("rerelease_idle", 64'(mem_req), 64'd0);
    @(posedge clk);
    #1;
    check_output("rerelease_req", 64'(mem_req), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
